// File: rtl/sram_burst_ctrl.sv
// Burst controller for the 16-bit asynchronous SRAM: splits BEATS x 16-bit
// host words into sequential SRAM cycles with wait states and byte enables.
module sram_burst_ctrl #(
   parameter int ADDR_W      = 20,
   parameter int BEATS       = 2,
   parameter int WAIT_CYCLES = 1,
   parameter int TURNAROUND  = 1,
   parameter int HA_W        = ADDR_W - $clog2(BEATS)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [HA_W-1:0]       req_addr,
   input  logic [16*BEATS-1:0]   req_wdata,
   input  logic [2*BEATS-1:0]    req_be,
   output logic                  rsp_valid,
   output logic [16*BEATS-1:0]   rsp_rdata,
   output logic                  wr_done,
   output logic [ADDR_W-1:0]     sram_addr,
   output logic [15:0]           sram_dq_out,
   output logic                  sram_dq_oe,
   input  logic [15:0]           sram_dq_in,
   output logic                  sram_ce_n,
   output logic                  sram_oe_n,
   output logic                  sram_we_n,
   output logic                  sram_lb_n,
   output logic                  sram_ub_n
);

   localparam int LB   = $clog2(BEATS);
   localparam int BW   = (LB > 0) ? LB : 1;
   localparam int CMAX = (WAIT_CYCLES > TURNAROUND) ? WAIT_CYCLES : TURNAROUND;
   localparam int CW   = (CMAX > 0) ? $clog2(CMAX + 1) : 1;

   localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);
   localparam logic [CW-1:0] STB_END   = CW'(WAIT_CYCLES);
   localparam logic [CW-1:0] TRN_END   = CW'((TURNAROUND > 0) ? TURNAROUND - 1 : 0);

   typedef enum logic [2:0] {
      S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_TURN
   } state_t;

   state_t                state;
   logic                  wr_q;
   logic [HA_W-1:0]       addr_q;
   logic [16*BEATS-1:0]   wdata_q;
   logic [16*BEATS-1:0]   rd_buf;
   logic [2*BEATS-1:0]    be_q;
   logic [BW-1:0]         beat;
   logic [CW-1:0]         cnt;

   logic                  go_setup;
   logic                  s_wr;
   logic [HA_W-1:0]       s_ha;
   logic [16*BEATS-1:0]   s_data;
   logic [2*BEATS-1:0]    s_be;
   logic [BW-1:0]         s_beat;
   logic [1:0]            s_bb;
   logic [15:0]           s_word;
   logic [ADDR_W-1:0]     s_addr;
   logic [1:0]            cur_bb;

   // Setup values come straight from the request on a handshake,
   // otherwise from the latched request for the following beat.
   always_comb begin
      go_setup = 1'b0;
      s_wr     = wr_q;
      s_ha     = addr_q;
      s_data   = wdata_q;
      s_be     = be_q;
      s_beat   = beat + 1'b1;
      if (state == S_IDLE) begin
         go_setup = req_valid && req_ready;
         s_wr     = req_write;
         s_ha     = req_addr;
         s_data   = req_wdata;
         s_be     = req_be;
         s_beat   = '0;
      end else if (state == S_HOLD) begin
         go_setup = (beat != LAST_BEAT);
      end
      s_bb   = s_be[2*s_beat +: 2];
      s_word = s_data[16*s_beat +: 16];
      s_addr = (ADDR_W'(s_ha) << LB) | ADDR_W'(s_beat);
      cur_bb = be_q[2*beat +: 2];
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_IDLE;
         req_ready   <= 1'b0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         wr_done     <= 1'b0;
         sram_addr   <= '0;
         sram_dq_out <= '0;
         sram_dq_oe  <= 1'b0;
         sram_ce_n   <= 1'b1;
         sram_oe_n   <= 1'b1;
         sram_we_n   <= 1'b1;
         sram_lb_n   <= 1'b1;
         sram_ub_n   <= 1'b1;
         wr_q        <= 1'b0;
         addr_q      <= '0;
         wdata_q     <= '0;
         be_q        <= '0;
         rd_buf      <= '0;
         beat        <= '0;
         cnt         <= '0;
      end else begin
         rsp_valid <= 1'b0;
         wr_done   <= 1'b0;
         unique case (state)
            S_IDLE: begin
               req_ready <= 1'b1;
               if (req_valid && req_ready) begin
                  req_ready <= 1'b0;
                  wr_q      <= req_write;
                  addr_q    <= req_addr;
                  wdata_q   <= req_wdata;
                  be_q      <= req_be;
                  beat      <= '0;
                  state     <= S_SETUP;
               end
            end
            S_SETUP: begin
               cnt       <= '0;
               sram_oe_n <= wr_q;
               sram_we_n <= !(wr_q && (cur_bb != 2'b00));
               state     <= S_STROBE;
            end
            S_STROBE: begin
               if (cnt == STB_END) begin
                  sram_oe_n <= 1'b1;
                  sram_we_n <= 1'b1;
                  if (!wr_q) rd_buf[16*beat +: 16] <= sram_dq_in;
                  state     <= S_HOLD;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_HOLD: begin
               if (beat != LAST_BEAT) begin
                  beat  <= beat + 1'b1;
                  state <= S_SETUP;
               end else begin
                  sram_ce_n  <= 1'b1;
                  sram_lb_n  <= 1'b1;
                  sram_ub_n  <= 1'b1;
                  sram_dq_oe <= 1'b0;
                  cnt        <= '0;
                  if (wr_q) begin
                     wr_done   <= 1'b1;
                     req_ready <= 1'b1;
                     state     <= S_IDLE;
                  end else begin
                     rsp_valid <= 1'b1;
                     rsp_rdata <= rd_buf;
                     if (TURNAROUND == 0) begin
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                     end else begin
                        state <= S_TURN;
                     end
                  end
               end
            end
            S_TURN: begin
               if (cnt == TRN_END) begin
                  req_ready <= 1'b1;
                  state     <= S_IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
         if (go_setup) begin
            sram_addr  <= s_addr;
            sram_ce_n  <= 1'b0;
            sram_oe_n  <= 1'b1;
            sram_we_n  <= 1'b1;
            sram_lb_n  <= s_wr ? !s_bb[0] : 1'b0;
            sram_ub_n  <= s_wr ? !s_bb[1] : 1'b0;
            sram_dq_oe <= s_wr;
            if (s_wr) sram_dq_out <= s_word;
         end
      end
   end

endmodule

// File: tb/tb_sram_burst_ctrl.sv
// Randomized bench for sram_burst_ctrl against an SRAM pin model and a
// host-word reference memory with spec-derived cycle timing.
module tb_sram_burst_ctrl;

   localparam int ADDR_W = 20;
   localparam int BEATS  = 2;
   localparam int WAITC  = 1;
   localparam int TURNA  = 1;
   localparam int HA_W   = ADDR_W - 1;
   localparam int P      = WAITC + 3;
   localparam int BP     = BEATS * P;

   logic              clk;
   logic              reset;
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [HA_W-1:0]   req_addr;
   logic [31:0]       req_wdata;
   logic [3:0]        req_be;
   logic              rsp_valid;
   logic [31:0]       rsp_rdata;
   logic              wr_done;
   logic [ADDR_W-1:0] sram_addr;
   logic [15:0]       sram_dq_out;
   logic              sram_dq_oe;
   logic [15:0]       sram_dq_in;
   logic              sram_ce_n;
   logic              sram_oe_n;
   logic              sram_we_n;
   logic              sram_lb_n;
   logic              sram_ub_n;

   sram_burst_ctrl #(
      .ADDR_W(ADDR_W), .BEATS(BEATS),
      .WAIT_CYCLES(WAITC), .TURNAROUND(TURNA)
   ) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_be(req_be),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .wr_done(wr_done), .sram_addr(sram_addr),
      .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
      .sram_dq_in(sram_dq_in), .sram_ce_n(sram_ce_n),
      .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
      .sram_lb_n(sram_lb_n), .sram_ub_n(sram_ub_n)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // SRAM pin model: unwritten words read back a fixed address pattern
   logic [15:0] sram [int];

   function automatic logic [15:0] init16(input int sa);
      return sa[15:0] ^ 16'h5A3C;
   endfunction

   function automatic logic [15:0] sram_rd(input int sa);
      if (sram.exists(sa)) return sram[sa];
      return init16(sa);
   endfunction

   always @(negedge clk) begin
      logic [15:0] w;
      if (!sram_ce_n && !sram_we_n) begin
         w = sram_rd(int'(sram_addr));
         if (!sram_lb_n) w[7:0] = sram_dq_out[7:0];
         if (!sram_ub_n) w[15:8] = sram_dq_out[15:8];
         sram[int'(sram_addr)] = w;
      end
      sram_dq_in = (!sram_ce_n && !sram_oe_n) ? sram_rd(int'(sram_addr)) : 16'h0000;
   end

   // Host-level reference memory
   logic [31:0] ref_mem [int];

   function automatic logic [31:0] ref_rd(input int ha);
      if (ref_mem.exists(ha)) return ref_mem[ha];
      return {init16(2*ha + 1), init16(2*ha)};
   endfunction

   task automatic ref_wr(input int ha, input logic [31:0] d, input logic [3:0] be);
      logic [31:0] w;
      w = ref_rd(ha);
      for (int i = 0; i < 4; i++)
         if (be[i]) w[8*i +: 8] = d[8*i +: 8];
      ref_mem[ha] = w;
   endtask

   int n_wd = 0;
   int n_rv = 0;
   int n_clash = 0;
   int exp_wd = 0;
   int exp_rv = 0;
   int t_hs;

   always @(negedge clk) begin
      if (wr_done) n_wd++;
      if (rsp_valid) n_rv++;
      if (sram_dq_oe && !sram_oe_n) n_clash++;
   end

   task automatic wait_ready();
      int n;
      n = 0;
      while (!req_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!req_ready) begin
         check("hs_timeout", 64'(req_ready), 64'd1);
         $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
         $fatal(1, "handshake timeout");
      end
   endtask

   task automatic do_req(input logic w, input logic [HA_W-1:0] a,
                         input logic [31:0] d, input logic [3:0] be,
                         input bit hold, output logic [31:0] rdata);
      int errs, perr, rerr, last, b, ph, ea;
      logic strobe;
      logic [1:0] bb;
      logic [31:0] rd_before;
      req_write = w;
      req_addr  = a;
      req_wdata = d;
      req_be    = be;
      req_valid = 1'b1;
      wait_ready();
      t_hs = cyc;
      rd_before = rsp_rdata;
      last = BP + 1 + (w ? 0 : TURNA);
      errs = 0; perr = 0; rerr = 0; rdata = '0;
      for (int k = 1; k <= last; k++) begin
         @(posedge clk); #1;
         if (k == 1) begin
            if (!hold) req_valid = 1'b0;
            req_write = 1'($urandom);
            req_addr  = HA_W'($urandom);
            req_wdata = $urandom;
            req_be    = 4'($urandom);
         end
         if (k <= BP) begin
            b  = (k - 1) / P;
            ph = (k - 1) % P;
            strobe = (ph >= 1 && ph <= WAITC + 1);
            bb = be[2*b +: 2];
            ea = int'(a) * BEATS + b;
            if (sram_ce_n !== 1'b0) errs++;
            if (int'(sram_addr) != ea) errs++;
            if (sram_oe_n !== !(!w && strobe)) errs++;
            if (sram_we_n !== !(w && strobe && bb != 2'b00)) errs++;
            if (sram_dq_oe !== w) errs++;
            if (w && sram_dq_out !== d[16*b +: 16]) errs++;
            if (ph <= WAITC + 1) begin
               if (sram_lb_n !== (w ? !bb[0] : 1'b0)) errs++;
               if (sram_ub_n !== (w ? !bb[1] : 1'b0)) errs++;
            end
         end else begin
            if (sram_ce_n !== 1'b1 || sram_oe_n !== 1'b1 ||
                sram_we_n !== 1'b1 || sram_dq_oe !== 1'b0) errs++;
         end
         if (wr_done !== (w && k == BP + 1)) perr++;
         if (rsp_valid !== (!w && k == BP + 1)) perr++;
         if (req_ready !== (k == last)) rerr++;
         if (!w && k == BP + 1) rdata = rsp_rdata;
      end
      check($sformatf("pins_%s_%h", w ? "wr" : "rd", a), 64'(errs), 64'd0);
      check("pulse_timing", 64'(perr), 64'd0);
      check("ready_timing", 64'(rerr), 64'd0);
      if (w) begin
         ref_wr(int'(a), d, be);
         check("rdata_held", 64'(rsp_rdata), 64'(rd_before));
         exp_wd++;
      end else begin
         check($sformatf("rdata_%h", a), 64'(rdata), 64'(ref_rd(int'(a))));
         exp_rv++;
      end
   endtask

   initial begin
      #300000;
      $display("FAIL watchdog cycles=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] rd;
      int t0;
      logic w;
      logic [HA_W-1:0] a;
      bit hold;
      reset = 1'b1;
      req_valid = 1'b0;
      req_write = 1'b0;
      req_addr = '0;
      req_wdata = '0;
      req_be = '0;
      sram_dq_in = '0;

      repeat (3) @(posedge clk);
      #1;
      check("rst_strobes", 64'({sram_ce_n, sram_oe_n, sram_we_n, sram_lb_n, sram_ub_n}), 64'h1F);
      check("rst_dq_oe", 64'(sram_dq_oe), 64'd0);
      check("rst_ready", 64'(req_ready), 64'd0);
      check("rst_pulses", 64'({rsp_valid, wr_done}), 64'd0);
      check("rst_addr_dq", 64'({sram_addr, sram_dq_out}), 64'd0);
      check("rst_rdata", 64'(rsp_rdata), 64'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("rel_ready", 64'(req_ready), 64'd1);

      do_req(1'b1, 19'h00005, 32'hDEADBEEF, 4'hF, 1'b0, rd);
      check("s2_mem", 64'({sram_rd(11), sram_rd(10)}), 64'hDEADBEEF);
      do_req(1'b0, 19'h00005, 32'h0, 4'h0, 1'b0, rd);
      check("s3_rdata", 64'(rd), 64'hDEADBEEF);
      do_req(1'b1, 19'h00005, 32'h00AA0000, 4'b0100, 1'b0, rd);
      do_req(1'b0, 19'h00005, 32'h0, 4'hF, 1'b0, rd);
      check("s4_rdata", 64'(rd), 64'hDEAABEEF);

      do_req(1'b0, 19'h00005, 32'h0, 4'h0, 1'b1, rd);
      t0 = t_hs;
      do_req(1'b1, 19'h00006, 32'h12345678, 4'hF, 1'b0, rd);
      check("s5_b2b_gap", 64'(t_hs - t0), 64'(BP + 1 + TURNA));

      do_req(1'b1, 19'h7FFFF, 32'hCAFEF00D, 4'hF, 1'b0, rd);
      do_req(1'b0, 19'h7FFFF, 32'h0, 4'h0, 1'b0, rd);
      check("s7_top", 64'({sram_rd(32'hFFFFF), sram_rd(32'hFFFFE)}), 64'hCAFEF00D);

      for (int i = 0; i < 40; i++) begin
         w = 1'($urandom);
         a = ($urandom % 8 == 0) ? 19'h7FFFF : HA_W'($urandom % 16);
         hold = ($urandom % 3 == 0) && (i != 39);
         do_req(w, a, $urandom, 4'($urandom), hold, rd);
         if (!hold) begin
            repeat ($urandom % 3) @(posedge clk);
            #1;
         end
      end
      req_valid = 1'b0;

      req_write = 1'b1;
      req_addr  = 19'h40000;
      req_wdata = $urandom;
      req_be    = 4'hF;
      req_valid = 1'b1;
      wait_ready();
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      check("s6_strobe", 64'(sram_we_n), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("s6_abort", 64'({sram_we_n, sram_ce_n, sram_dq_oe, req_ready}), 64'b1100);
      reset = 1'b0;
      repeat (BP + 2) @(posedge clk);
      #1;
      do_req(1'b0, 19'h00005, 32'h0, 4'h0, 1'b0, rd);
      repeat (4) @(posedge clk);
      #1;

      check("wr_done_count", 64'(n_wd), 64'(exp_wd));
      check("rsp_valid_count", 64'(n_rv), 64'(exp_rv));
      check("oe_clash", 64'(n_clash), 64'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
